computron_core: RTL and testbench

COMPUTRON_CORE -- requirements
Module: computron_core

---
 rtl/computron_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_computron_core.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computron_core.sv
// computron_core: a small multi-cycle accumulator-less register machine.
// Each instruction is two memory words (W1: opcode/rd, W2: rs1/rs2 or an
// address). The core fetches both words, executes, and for LOAD/STORE performs
// one extra data access through the same memory port.
//
// Ports:
//   clock      - sole clock, all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   mem_req    - memory access request (registered)
//   mem_we     - 1 = store for the current request (registered)
//   mem_addr   - access address (registered)
//   mem_wdata  - store data (registered)
//   mem_ready  - access completes on a cycle with mem_req=1 and mem_ready=1
//   mem_rdata  - read data, valid on the completing cycle
//   halted     - core stopped by HALT
//   pc         - current program counter
//   retired    - 16-bit count of executed instructions (wraps)
module computron_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [15:0]           retired
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int MSB      = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] PC_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd7;
    localparam logic [3:0] OP_JZ    = 4'd8;
    localparam logic [3:0] OP_JV    = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // The instruction fields must fit inside one word.
    generate
        if ((DATA_WIDTH < 4 + REG_ADDR_WIDTH) || (DATA_WIDTH < 2 * REG_ADDR_WIDTH)) begin : g_param_check
            $error("computron_core: DATA_WIDTH too small for REG_ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_FETCH1 = 3'd0,
        ST_FETCH2 = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]       pc_r, pc_nxt_s;
    logic [3:0]                  op_r;
    logic [REG_ADDR_WIDTH-1:0]   rd_r;
    logic [DATA_WIDTH-1:0]       ir2_r;
    logic [DATA_WIDTH-1:0]       regs_r [NUM_REGS];
    logic                        z_r, v_r;
    logic [15:0]                 retired_r;
    logic                        halted_r;
    logic                        mem_req_r, mem_we_r;
    logic [DATA_WIDTH-1:0]       mem_addr_r, mem_wdata_r;
    logic                        mem_req_s, mem_we_s;
    logic [DATA_WIDTH-1:0]       mem_addr_s, mem_wdata_s;

    logic                        done_s;
    logic                        is_mem_op_s;
    logic [DATA_WIDTH-1:0]       opa_s, opb_s, alu_res_s;
    logic                        alu_v_s, alu_wr_s, jump_s;

    assign done_s      = mem_req_r & mem_ready;
    assign is_mem_op_s = (op_r == OP_LOAD) || (op_r == OP_STORE);
    assign opa_s       = regs_r[ir2_r[2*REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]];
    assign opb_s       = regs_r[ir2_r[REG_ADDR_WIDTH-1:0]];

    // ALU result, overflow and jump decision for the latched instruction.
    always_comb begin
        alu_res_s = '0;
        alu_v_s   = 1'b0;
        alu_wr_s  = 1'b0;
        jump_s    = 1'b0;
        case (op_r)
            OP_ADD: begin
                alu_res_s = opa_s + opb_s;
                alu_v_s   = (opa_s[MSB] == opb_s[MSB]) && (alu_res_s[MSB] != opa_s[MSB]);
                alu_wr_s  = 1'b1;
            end
            OP_SUB: begin
                alu_res_s = opa_s - opb_s;
                alu_v_s   = (opa_s[MSB] != opb_s[MSB]) && (alu_res_s[MSB] != opa_s[MSB]);
                alu_wr_s  = 1'b1;
            end
            OP_AND: begin
                alu_res_s = opa_s & opb_s;
                alu_wr_s  = 1'b1;
            end
            OP_OR: begin
                alu_res_s = opa_s | opb_s;
                alu_wr_s  = 1'b1;
            end
            OP_JMP:  jump_s = 1'b1;
            OP_JZ:   jump_s = z_r;
            OP_JV:   jump_s = v_r;
            default: jump_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH1: begin
                if (done_s) state_nxt_s = ST_FETCH2;
                else        state_nxt_s = ST_FETCH1;
            end
            ST_FETCH2: begin
                if (done_s) state_nxt_s = ST_EXEC;
                else        state_nxt_s = ST_FETCH2;
            end
            ST_EXEC: begin
                if (is_mem_op_s)          state_nxt_s = ST_MEM;
                else if (op_r == OP_HALT) state_nxt_s = ST_HALT;
                else                      state_nxt_s = ST_FETCH1;
            end
            ST_MEM: begin
                if (done_s) state_nxt_s = ST_FETCH1;
                else        state_nxt_s = ST_MEM;
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_FETCH1;
        endcase
    end

    // Next program counter: advance per fetched word, or load a taken jump target.
    always_comb begin
        pc_nxt_s = pc_r;
        if (((state_r == ST_FETCH1) || (state_r == ST_FETCH2)) && done_s) begin
            pc_nxt_s = pc_r + PC_ONE;
        end else if ((state_r == ST_EXEC) && jump_s) begin
            pc_nxt_s = ir2_r;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Output logic, decoded from the next state so the registered memory
    // outputs line up with the state they belong to; they only change when an
    // access completes, which keeps them stable during wait states.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        case (state_nxt_s)
            ST_FETCH1, ST_FETCH2: begin
                mem_req_s  = 1'b1;
                mem_addr_s = pc_nxt_s;
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                mem_addr_s = ir2_r;
                if (op_r == OP_STORE) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = regs_r[rd_r];
                end else begin
                    mem_we_s    = 1'b0;
                    mem_wdata_s = '0;
                end
            end
            default: mem_req_s = 1'b0;
        endcase
    end

    // Registered outputs and program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r        <= '0;
            halted_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            pc_r        <= pc_nxt_s;
            halted_r    <= (state_nxt_s == ST_HALT);
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // Instruction latches, register file, flags and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r      <= 4'd0;
            rd_r      <= '0;
            ir2_r     <= '0;
            z_r       <= 1'b0;
            v_r       <= 1'b0;
            retired_r <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if ((state_r == ST_FETCH1) && done_s) begin
                op_r <= mem_rdata[DATA_WIDTH-1 -: 4];
                rd_r <= mem_rdata[REG_ADDR_WIDTH-1:0];
            end
            if ((state_r == ST_FETCH2) && done_s) begin
                ir2_r <= mem_rdata;
            end
            // Operands come from regs_r before this edge, so rd==rs reads old values.
            if ((state_r == ST_EXEC) && alu_wr_s) begin
                regs_r[rd_r] <= alu_res_s;
                z_r          <= (alu_res_s == '0);
                v_r          <= alu_v_s;
            end
            if ((state_r == ST_MEM) && done_s && (op_r == OP_LOAD)) begin
                regs_r[rd_r] <= mem_rdata;
            end
            if (((state_r == ST_EXEC) && !is_mem_op_s) || ((state_r == ST_MEM) && done_s)) begin
                retired_r <= retired_r + 16'd1;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign halted    = halted_r;
    assign pc        = pc_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_computron_core.sv
// Testbench for computron_core: an 8-bit core runs a directed program against a
// memory model, a 16-bit core runs a short program across the address wrap.
// Expected memory accesses are queued up front; monitors pop and compare each
// completed access.
module tb_computron_core;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic clock;
    logic reset8, reset16;

    logic       mem_req8, mem_we8, halted8, ready8;
    logic [7:0] addr8, wdata8, rdata8, pc8;
    logic [15:0] retired8;

    logic        mem_req16, mem_we16, halted16;
    logic        ready16 = 1'b1;
    logic [15:0] addr16, wdata16, rdata16, pc16, retired16;

    logic [7:0] mem8 [256];
    acc_t       q8 [$];
    acc_t       q16 [$];

    int n_tests = 0;
    int n_fail  = 0;

    logic force_low = 1'b0;
    logic stall8    = 1'b0;
    int   stall_cnt = 0;
    int   hold_cnt  = 0;
    int   store30   = 0;
    logic stable_ok = 1'b1;
    logic [7:0] hold_addr, hold_wdata;
    int   acc8_idx  = 0;
    int   acc16_idx = 0;

    computron_core #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(4)) dut8 (
        .clock(clock), .reset(reset8),
        .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_ready(ready8), .mem_rdata(rdata8),
        .halted(halted8), .pc(pc8), .retired(retired8)
    );

    computron_core #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut16 (
        .clock(clock), .reset(reset16),
        .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_ready(ready16), .mem_rdata(rdata16),
        .halted(halted16), .pc(pc16), .retired(retired16)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // 16-bit program: LOAD,LOAD,JMP FFF6; ADD; JV FFFC; STORE; HALT at FFFE.
    function automatic logic [15:0] rom16(input logic [15:0] a);
        case (a)
            16'h0000: rom16 = 16'h5001;
            16'h0001: rom16 = 16'h0100;
            16'h0002: rom16 = 16'h5002;
            16'h0003: rom16 = 16'h0101;
            16'h0004: rom16 = 16'h7000;
            16'h0005: rom16 = 16'hFFF6;
            16'hFFF6: rom16 = 16'h1003;
            16'hFFF7: rom16 = 16'h0012;
            16'hFFF8: rom16 = 16'h9000;
            16'hFFF9: rom16 = 16'hFFFC;
            16'hFFFA: rom16 = 16'hF000;
            16'hFFFC: rom16 = 16'h6003;
            16'hFFFD: rom16 = 16'h0200;
            16'hFFFE: rom16 = 16'hF000;
            16'h0100: rom16 = 16'h7FFF;
            16'h0101: rom16 = 16'h0001;
            default:  rom16 = 16'h0000;
        endcase
    endfunction

    assign rdata16 = rom16(addr16);
    assign rdata8  = mem8[addr8];
    assign ready8  = !force_low && !stall8;

    function automatic void exp8(input logic we, input logic [7:0] a, input logic [7:0] d);
        acc_t e;
        e.we = we; e.addr = {8'h00, a}; e.wdata = {8'h00, d};
        q8.push_back(e);
    endfunction

    function automatic void fetch8(input logic [7:0] a);
        exp8(1'b0, a, 8'h00);
        exp8(1'b0, a + 8'd1, 8'h00);
    endfunction

    function automatic void exp16(input logic we, input logic [15:0] a, input logic [15:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d;
        q16.push_back(e);
    endfunction

    function automatic void put8(input logic [7:0] a, input logic [7:0] w1, input logic [7:0] w2);
        mem8[a]        = w1;
        mem8[a + 8'd1] = w2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait-state generator: hold off the store to 0x30 for three cycles.
    always @(posedge clock) begin
        #1;
        if (mem_req8 && mem_we8 && (addr8 == 8'h30) && (stall_cnt < 3)) begin
            stall8 = 1'b1;
            stall_cnt++;
        end else begin
            stall8 = 1'b0;
        end
    end

    // Store-hold observer: count cycles and confirm outputs stay put.
    always @(negedge clock) begin
        if (mem_req8 && mem_we8 && (addr8 == 8'h30)) begin
            hold_cnt++;
            if (hold_cnt == 1) begin
                hold_addr  = addr8;
                hold_wdata = wdata8;
            end else if ((addr8 !== hold_addr) || (wdata8 !== hold_wdata)) begin
                stable_ok = 1'b0;
            end
        end
    end

    // Monitor for the 8-bit core: every completing access is checked against the queue.
    always @(negedge clock) begin
        acc_t e;
        if (!reset8 && mem_req8 && ready8) begin
            n_tests++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL acc8 unexpected: got we=%0b addr=%0h wdata=%0h, expected none", mem_we8, addr8, wdata8);
            end else begin
                e = q8.pop_front();
                if ((mem_we8 !== e.we) || (addr8 !== e.addr[7:0]) || (e.we && (wdata8 !== e.wdata[7:0]))) begin
                    n_fail++;
                    $display("FAIL acc8[%0d]: got we=%0b addr=%0h wdata=%0h, expected we=%0b addr=%0h wdata=%0h",
                             acc8_idx, mem_we8, addr8, wdata8, e.we, e.addr[7:0], e.wdata[7:0]);
                end
            end
            acc8_idx++;
            if (mem_we8) begin
                mem8[addr8] = wdata8;
                if (addr8 == 8'h30) store30++;
            end
        end
    end

    // Monitor for the 16-bit core.
    always @(negedge clock) begin
        acc_t e;
        if (!reset16 && mem_req16 && ready16) begin
            n_tests++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL acc16 unexpected: got we=%0b addr=%0h wdata=%0h, expected none", mem_we16, addr16, wdata16);
            end else begin
                e = q16.pop_front();
                if ((mem_we16 !== e.we) || (addr16 !== e.addr) || (e.we && (wdata16 !== e.wdata))) begin
                    n_fail++;
                    $display("FAIL acc16[%0d]: got we=%0b addr=%0h wdata=%0h, expected we=%0b addr=%0h wdata=%0h",
                             acc16_idx, mem_we16, addr16, wdata16, e.we, e.addr, e.wdata);
                end
            end
            acc16_idx++;
        end
    end

    initial begin
        int   t;
        logic req_seen;
        reset8  = 1'b1;
        reset16 = 1'b1;
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        put8(8'h00, 8'h51, 8'h20);  // LOAD r1,[0x20]
        put8(8'h02, 8'h52, 8'h21);  // LOAD r2,[0x21]
        put8(8'h04, 8'h13, 8'h12);  // ADD r3=r1+r2 -> 0x80, V=1
        put8(8'h06, 8'h24, 8'h11);  // SUB r4=r1-r1 -> 0, Z=1
        put8(8'h08, 8'h80, 8'h40);  // JZ 0x40 (taken)
        put8(8'h40, 8'h63, 8'h30);  // STORE r3,[0x30] (wait states)
        put8(8'h42, 8'h90, 8'h50);  // JV 0x50 (not taken)
        put8(8'h44, 8'h15, 8'h33);  // ADD r5=r3+r3 -> 0, V=1
        put8(8'h46, 8'h90, 8'h60);  // JV 0x60 (taken)
        put8(8'h60, 8'h41, 8'h13);  // OR r1=r1|r3 -> 0xF0
        put8(8'h62, 8'h36, 8'h12);  // AND r6=r1&r2 -> 0x10
        put8(8'h64, 8'h61, 8'h31);  // STORE r1,[0x31]
        put8(8'h66, 8'h66, 8'h32);  // STORE r6,[0x32]
        put8(8'h68, 8'h80, 8'h10);  // JZ 0x10 (not taken)
        put8(8'h6A, 8'hA0, 8'h00);  // opcode 10 -> NOP
        put8(8'h6C, 8'h70, 8'hFE);  // JMP 0xFE
        put8(8'hFE, 8'hF0, 8'h00);  // HALT
        mem8[8'h20] = 8'h70;
        mem8[8'h21] = 8'h10;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_pc", pc8, 0);
        chk("rst_halted", halted8, 0);
        chk("rst_retired", retired8, 0);
        chk("rst_req", mem_req8, 0);
        chk("rst_we", mem_we8, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_wdata", wdata8, 0);
        chk("rst16_pc", pc16, 0);
        chk("rst16_req", mem_req16, 0);

        fetch8(8'h00); exp8(1'b0, 8'h20, 8'h00);
        fetch8(8'h02); exp8(1'b0, 8'h21, 8'h00);
        fetch8(8'h04); fetch8(8'h06); fetch8(8'h08);
        fetch8(8'h40); exp8(1'b1, 8'h30, 8'h80);
        fetch8(8'h42); fetch8(8'h44); fetch8(8'h46);
        fetch8(8'h60); fetch8(8'h62);
        fetch8(8'h64); exp8(1'b1, 8'h31, 8'hF0);
        fetch8(8'h66); exp8(1'b1, 8'h32, 8'h10);
        fetch8(8'h68); fetch8(8'h6A); fetch8(8'h6C); fetch8(8'hFE);

        @(posedge clock); #1 reset8 = 1'b0;

        // First request cycle counts as cycle 1 of the LOAD/LOAD/ADD sequence.
        t = 0;
        @(negedge clock);
        while (!mem_req8 && (t < 10)) begin @(negedge clock); t++; end
        chk("first_req", mem_req8, 1);
        chk("first_addr", addr8, 0);
        repeat (10) @(negedge clock);
        chk("retired_cyc11", retired8, 2);
        @(negedge clock);
        chk("retired_cyc12", retired8, 3);

        t = 0;
        while (!halted8 && (t < 400)) begin @(negedge clock); t++; end
        chk("halted", halted8, 1);
        chk("halt_pc_wrap", pc8, 0);
        chk("halt_retired", retired8, 17);
        req_seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (mem_req8) req_seen = 1'b1;
        end
        chk("halt_no_req", req_seen, 0);
        chk("halt_retired_hold", retired8, 17);
        chk("halt_pc_hold", pc8, 0);
        chk("q8_drained", q8.size(), 0);
        chk("store30_once", store30, 1);
        chk("store30_hold", hold_cnt, 4);
        chk("store30_stable", stable_ok, 1);
        chk("mem30", mem8[8'h30], 8'h80);
        chk("mem31", mem8[8'h31], 8'hF0);
        chk("mem32", mem8[8'h32], 8'h10);

        // Reset out of HALT, then reset again while stalled in FETCH2.
        exp8(1'b0, 8'h00, 8'h00);
        @(posedge clock); #1 reset8 = 1'b1;
        @(posedge clock); #1 reset8 = 1'b0;
        t = 0;
        @(negedge clock);
        while (!(mem_req8 && (addr8 == 8'h00)) && (t < 10)) begin @(negedge clock); t++; end
        chk("restart_req", mem_req8, 1);
        @(posedge clock); #1 force_low = 1'b1;
        @(negedge clock);
        chk("f2_req", mem_req8, 1);
        chk("f2_addr", addr8, 1);
        @(posedge clock); #1 reset8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst2_pc", pc8, 0);
        chk("rst2_req", mem_req8, 0);
        chk("rst2_we", mem_we8, 0);
        chk("rst2_addr", addr8, 0);
        chk("rst2_wdata", wdata8, 0);
        chk("rst2_retired", retired8, 0);
        chk("rst2_halted", halted8, 0);
        reset8 = 1'b0;
        @(negedge clock);
        chk("rst2_refetch_req", mem_req8, 1);
        chk("rst2_refetch_addr", addr8, 0);
        chk("rst2_refetch_pc", pc8, 0);
        chk("q8_after_reset", q8.size(), 0);

        // 16-bit core: ADD 0x7FFF+1 sets V, JV taken, store of 0x8000, pc wraps.
        exp16(1'b0, 16'h0000, 16'h0); exp16(1'b0, 16'h0001, 16'h0); exp16(1'b0, 16'h0100, 16'h0);
        exp16(1'b0, 16'h0002, 16'h0); exp16(1'b0, 16'h0003, 16'h0); exp16(1'b0, 16'h0101, 16'h0);
        exp16(1'b0, 16'h0004, 16'h0); exp16(1'b0, 16'h0005, 16'h0);
        exp16(1'b0, 16'hFFF6, 16'h0); exp16(1'b0, 16'hFFF7, 16'h0);
        exp16(1'b0, 16'hFFF8, 16'h0); exp16(1'b0, 16'hFFF9, 16'h0);
        exp16(1'b0, 16'hFFFC, 16'h0); exp16(1'b0, 16'hFFFD, 16'h0);
        exp16(1'b1, 16'h0200, 16'h8000);
        exp16(1'b0, 16'hFFFE, 16'h0); exp16(1'b0, 16'hFFFF, 16'h0);
        @(posedge clock); #1 reset16 = 1'b0;
        t = 0;
        @(negedge clock);
        while (!halted16 && (t < 200)) begin @(negedge clock); t++; end
        chk("h16_halted", halted16, 1);
        chk("h16_pc_wrap", pc16, 0);
        chk("h16_retired", retired16, 7);
        chk("h16_req", mem_req16, 0);
        chk("q16_drained", q16.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
